// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage in-order pipeline (EX -> MEM -> WB).
// Registers the EX_to_MEM bus under the valid/allow_in handshake, merges the
// synchronous data-SRAM read data for loads (with a hold register so load data
// survives WB back-pressure), and drives the MEM_to_WB bus and the ID forwarding bus.
//
// Ports:
//   clk              pipeline clock, all state updates on posedge
//   resetn           asynchronous active-low reset
//   EX_to_MEM_valid  EX holds a valid instruction for MEM
//   EX_to_MEM_bus    {alu_result[31:0], res_from_mem, mem_op[2:0], gr_we, dest[4:0], pc[31:0], inst[31:0]}
//   MEM_allow_in     MEM accepts a new instruction at this edge
//   data_sram_rdata  read data for the request EX issued in the previous cycle
//   WB_allow_in      WB accepts at this edge
//   MEM_to_WB_valid  MEM presents a valid instruction to WB
//   MEM_to_WB_bus    {final_result[31:0], gr_we, dest[4:0], pc[31:0], inst[31:0]}
//   MEM_to_ID_bus    {fwd_we, dest[4:0], final_result[31:0]}
module mem_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic         EX_to_MEM_valid,
    input  logic [105:0] EX_to_MEM_bus,
    output logic         MEM_allow_in,
    input  logic [31:0]  data_sram_rdata,
    input  logic         WB_allow_in,
    output logic         MEM_to_WB_valid,
    output logic [101:0] MEM_to_WB_bus,
    output logic [37:0]  MEM_to_ID_bus
);

    logic         r_mem_valid;
    logic [105:0] r_bus;
    logic         r_first;
    logic [31:0]  r_rdata_hold;

    logic         w_ready_go;
    logic         w_load_en;
    logic [31:0]  w_alu_result;
    logic         w_res_from_mem;
    logic [2:0]   w_mem_op;
    logic         w_gr_we;
    logic [4:0]   w_dest;
    logic [31:0]  w_pc;
    logic [31:0]  w_inst;
    logic [1:0]   w_off;
    logic [31:0]  w_eff;
    logic [7:0]   w_byte;
    logic [15:0]  w_half;
    logic [31:0]  w_load_data;
    logic [31:0]  w_final_result;

    assign w_ready_go      = 1'b1;
    assign MEM_allow_in    = ~r_mem_valid | (w_ready_go & WB_allow_in);
    assign MEM_to_WB_valid = r_mem_valid & w_ready_go;
    assign w_load_en       = EX_to_MEM_valid & MEM_allow_in;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_valid  <= 1'b0;
            r_bus        <= '0;
            r_first      <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            if (MEM_allow_in) begin
                r_mem_valid <= EX_to_MEM_valid;
            end
            if (w_load_en) begin
                r_bus <= EX_to_MEM_bus;
            end
            // first marks the single cycle in which the SRAM output belongs to
            // the instruction now in MEM; a back-to-back load sets it again.
            r_first <= w_load_en;
            if (r_first) begin
                r_rdata_hold <= data_sram_rdata;
            end
        end
    end

    assign w_alu_result   = r_bus[105:74];
    assign w_res_from_mem = r_bus[73];
    assign w_mem_op       = r_bus[72:70];
    assign w_gr_we        = r_bus[69];
    assign w_dest         = r_bus[68:64];
    assign w_pc           = r_bus[63:32];
    assign w_inst         = r_bus[31:0];
    assign w_off          = w_alu_result[1:0];

    // Live SRAM data is only valid in the first cycle; afterwards use the copy.
    assign w_eff  = r_first ? data_sram_rdata : r_rdata_hold;
    assign w_half = w_off[1] ? w_eff[31:16] : w_eff[15:0];

    always_comb begin
        w_byte = w_eff[7:0];
        case (w_off)
            2'd0: w_byte = w_eff[7:0];
            2'd1: w_byte = w_eff[15:8];
            2'd2: w_byte = w_eff[23:16];
            2'd3: w_byte = w_eff[31:24];
            default: w_byte = w_eff[7:0];
        endcase
    end

    always_comb begin
        w_load_data = w_eff;
        case (w_mem_op)
            3'b001: w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b011: w_load_data = {24'd0, w_byte};
            3'b010: w_load_data = {{16{w_half[15]}}, w_half};
            3'b100: w_load_data = {16'd0, w_half};
            default: w_load_data = w_eff;
        endcase
    end

    assign w_final_result = w_res_from_mem ? w_load_data : w_alu_result;

    assign MEM_to_WB_bus = {w_final_result, w_gr_we, w_dest, w_pc, w_inst};
    assign MEM_to_ID_bus = {r_mem_valid & w_gr_we, w_dest, w_final_result};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic         clk;
    logic         resetn;
    logic         EX_to_MEM_valid;
    logic [105:0] EX_to_MEM_bus;
    logic         MEM_allow_in;
    logic [31:0]  data_sram_rdata;
    logic         WB_allow_in;
    logic         MEM_to_WB_valid;
    logic [101:0] MEM_to_WB_bus;
    logic [37:0]  MEM_to_ID_bus;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .EX_to_MEM_valid (EX_to_MEM_valid),
        .EX_to_MEM_bus   (EX_to_MEM_bus),
        .MEM_allow_in    (MEM_allow_in),
        .data_sram_rdata (data_sram_rdata),
        .WB_allow_in     (WB_allow_in),
        .MEM_to_WB_valid (MEM_to_WB_valid),
        .MEM_to_WB_bus   (MEM_to_WB_bus),
        .MEM_to_ID_bus   (MEM_to_ID_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [105:0] mk(input logic [31:0] alu, input logic rfm,
                                        input logic [2:0] op, input logic we,
                                        input logic [4:0] dest, input logic [31:0] pc,
                                        input logic [31:0] inst);
        return {alu, rfm, op, we, dest, pc, inst};
    endfunction

    task automatic check(input string tag, input logic [105:0] obs, input logic [105:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ld_off [8];
    logic [2:0]  ld_op  [8];
    logic [31:0] ld_exp [8];

    initial begin
        resetn          = 1'b0;
        EX_to_MEM_valid = 1'b0;
        EX_to_MEM_bus   = '0;
        data_sram_rdata = '0;
        WB_allow_in     = 1'b1;
        #1;
        check("rst_allow_in", 106'(MEM_allow_in), 106'(1));
        check("rst_wb_valid", 106'(MEM_to_WB_valid), 106'(0));
        check("rst_wb_bus",   106'(MEM_to_WB_bus), 106'(0));
        check("rst_id_bus",   106'(MEM_to_ID_bus), 106'(0));
        tick;
        tick;
        resetn = 1'b1;

        // Idle after reset release.
        for (int i = 0; i < 10; i++) begin
            tick;
            check("idle_allow_in", 106'(MEM_allow_in), 106'(1));
            check("idle_wb_valid", 106'(MEM_to_WB_valid), 106'(0));
            check("idle_id_bus",   106'(MEM_to_ID_bus), 106'(0));
        end

        // Back-to-back ALU ops, alu_result 1,2,3, dest 5.
        EX_to_MEM_valid = 1'b1;
        EX_to_MEM_bus   = mk(32'd1, 1'b0, 3'b000, 1'b1, 5'd5, 32'h1000, 32'hA1);
        #1;
        check("b2b_pre_valid", 106'(MEM_to_WB_valid), 106'(0));
        for (int i = 1; i <= 3; i++) begin
            tick;
            if (i < 3) EX_to_MEM_bus = mk(32'(i + 1), 1'b0, 3'b000, 1'b1, 5'd5, 32'h1000 + 32'(4 * i), 32'hA1);
            else EX_to_MEM_valid = 1'b0;
            #1;
            check("b2b_valid",  106'(MEM_to_WB_valid), 106'(1));
            check("b2b_final",  106'(MEM_to_WB_bus[101:70]), 106'(i));
            check("b2b_pc",     106'(MEM_to_WB_bus[63:32]), 106'(32'h1000 + 32'(4 * (i - 1))));
            check("b2b_id_bus", 106'(MEM_to_ID_bus), 106'({1'b1, 5'd5, 32'(i)}));
        end
        tick;
        check("b2b_post_valid", 106'(MEM_to_WB_valid), 106'(0));
        check("b2b_bubble_fwd", 106'(MEM_to_ID_bus[37]), 106'(0));

        // Load extraction, back-to-back, rdata = 0x8081_F27F.
        ld_off[0] = 0; ld_op[0] = 3'b001; ld_exp[0] = 32'h0000_007F;
        ld_off[1] = 1; ld_op[1] = 3'b001; ld_exp[1] = 32'hFFFF_FFF2;
        ld_off[2] = 3; ld_op[2] = 3'b011; ld_exp[2] = 32'h0000_0080;
        ld_off[3] = 2; ld_op[3] = 3'b010; ld_exp[3] = 32'hFFFF_8081;
        ld_off[4] = 0; ld_op[4] = 3'b100; ld_exp[4] = 32'h0000_F27F;
        ld_off[5] = 0; ld_op[5] = 3'b000; ld_exp[5] = 32'h8081_F27F;
        ld_off[6] = 3; ld_op[6] = 3'b010; ld_exp[6] = 32'hFFFF_8081;
        ld_off[7] = 2; ld_op[7] = 3'b001; ld_exp[7] = 32'hFFFF_FF81;
        data_sram_rdata = 32'h8081_F27F;
        for (int i = 0; i < 8; i++) begin
            EX_to_MEM_valid = 1'b1;
            EX_to_MEM_bus   = mk(32'h0000_2000 | ld_off[i], 1'b1, ld_op[i], 1'b1, 5'd7, 32'h2000, 32'hB2);
            tick;
            #1;
            check("load_valid", 106'(MEM_to_WB_valid), 106'(1));
            check("load_final", 106'(MEM_to_WB_bus[101:70]), 106'(ld_exp[i]));
        end
        EX_to_MEM_valid = 1'b0;
        tick;

        // Stall hold: ld.w, rdata changes after the first cycle.
        EX_to_MEM_valid = 1'b1;
        EX_to_MEM_bus   = mk(32'h0000_3000, 1'b1, 3'b000, 1'b1, 5'd9, 32'h3000, 32'hC3);
        data_sram_rdata = 32'h1234_5678;
        tick;
        WB_allow_in     = 1'b0;
        EX_to_MEM_bus   = mk(32'h0000_4444, 1'b0, 3'b000, 1'b1, 5'd3, 32'h4444, 32'hD4);
        #1;
        for (int c = 0; c < 3; c++) begin
            check("stall_allow_in", 106'(MEM_allow_in), 106'(0));
            check("stall_valid",    106'(MEM_to_WB_valid), 106'(1));
            check("stall_final",    106'(MEM_to_WB_bus[101:70]), 106'(32'h1234_5678));
            check("stall_pc",       106'(MEM_to_WB_bus[63:32]), 106'(32'h3000));
            tick;
            data_sram_rdata = 32'hDEAD_BEEF;
            if (c == 2) begin
                WB_allow_in     = 1'b1;
                EX_to_MEM_valid = 1'b0;
            end
            #1;
        end
        check("retire_allow_in", 106'(MEM_allow_in), 106'(1));
        check("retire_valid",    106'(MEM_to_WB_valid), 106'(1));
        check("retire_final",    106'(MEM_to_WB_bus[101:70]), 106'(32'h1234_5678));
        tick;
        check("retired_valid", 106'(MEM_to_WB_valid), 106'(0));

        // Non-load with toggling rdata, held in stall.
        EX_to_MEM_valid = 1'b1;
        EX_to_MEM_bus   = mk(32'hCAFE_0000, 1'b0, 3'b000, 1'b1, 5'd11, 32'h5000, 32'hE5);
        tick;
        EX_to_MEM_valid = 1'b0;
        WB_allow_in     = 1'b0;
        for (int c = 0; c < 3; c++) begin
            data_sram_rdata = (c % 2 == 0) ? 32'h5555_AAAA : 32'hAAAA_5555;
            #1;
            check("nonload_final", 106'(MEM_to_WB_bus[101:70]), 106'(32'hCAFE_0000));
            tick;
        end

        // Reset asserted between edges while stalled.
        check("prereset_valid", 106'(MEM_to_WB_valid), 106'(1));
        #1;
        resetn = 1'b0;
        #1;
        check("midreset_valid",    106'(MEM_to_WB_valid), 106'(0));
        check("midreset_allow_in", 106'(MEM_allow_in), 106'(1));
        check("midreset_wb_bus",   106'(MEM_to_WB_bus), 106'(0));
        tick;
        #2;
        resetn      = 1'b1;
        WB_allow_in = 1'b1;
        tick;
        check("postreset_allow_in", 106'(MEM_allow_in), 106'(1));
        check("postreset_valid",    106'(MEM_to_WB_valid), 106'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
